// File: rtl/msc_result_acc.sv
// msc_result_acc: multi-slope receive side. Balances the runup, times the rundown and emits a signed result.
// Define MSC_AUTOZERO_EN to store an autozero offset and subtract it from later results.
module msc_result_acc #(
  parameter int RU_W     = 16,
  parameter int RD_W     = 12,
  parameter int RD_MAX   = 4095,
  parameter int RD_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       runup,
  input  logic                       zero,
  input  logic                       comp,
  input  logic                       az,
  output logic                       ru_pos,
  output logic                       rd_en,
  output logic                       rd_pol,
  output logic                       busy,
  output logic [RU_W+RD_SHIFT+1:0]   result,
  output logic                       valid,
  output logic                       ovf,
  output logic                       err
);
  localparam int RES_W = RU_W + RD_SHIFT + 2;
  localparam logic [RU_W-1:0] RU_SAT = '1;

  typedef enum logic [2:0] {IDLE, ARM, RUNUP, RUNDOWN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RU_W-1:0]   pos_cnt_q, pos_cnt_d, neg_cnt_q, neg_cnt_d;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic              ru_pos_q, ru_pos_d, rd_en_q, rd_en_d, rd_pol_q, rd_pol_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, err_q, err_d;
  logic [RES_W-1:0]  net, raw;
  logic              do_step, do_exit, do_abort, timeout;
`ifdef MSC_AUTOZERO_EN
  logic              az_q, az_d;
  logic [RES_W-1:0]  offset_q, offset_d;
`else
  logic              az_unused;
  assign az_unused = az;
`endif

  // Two's complement arithmetic in RES_W bits; the width leaves headroom so nothing wraps.
  always_comb begin
    net = RES_W'(pos_cnt_q) - RES_W'(neg_cnt_q);
    raw = (net << RD_SHIFT) + (rd_pol_q ? RES_W'(rd_cnt_q) : -RES_W'(rd_cnt_q));
  end

  always_comb begin
    state_d    = state_q;
    pos_cnt_d  = pos_cnt_q;
    neg_cnt_d  = neg_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    ovf_flag_d = ovf_flag_q;
    ru_pos_d   = ru_pos_q;
    rd_en_d    = rd_en_q;
    rd_pol_d   = rd_pol_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    do_step    = 1'b0;
    do_exit    = 1'b0;
    do_abort   = 1'b0;
    timeout    = 1'b0;
`ifdef MSC_AUTOZERO_EN
    az_d       = az_q;
    offset_d   = offset_q;
`endif
    if (start) begin
      state_d    = ARM;
      pos_cnt_d  = '0;
      neg_cnt_d  = '0;
      rd_cnt_d   = '0;
      ovf_flag_d = 1'b0;
      ru_pos_d   = 1'b0;
      rd_en_d    = 1'b0;
`ifdef MSC_AUTOZERO_EN
      az_d       = az;
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ARM: begin
          if (zero) do_abort = 1'b1;
          else if (runup) begin
            state_d = RUNUP;
            do_step = 1'b1;
          end
        end
        RUNUP: begin
          if (zero) do_abort = 1'b1;
          else if (runup) do_step = 1'b1;
          else begin
            rd_pol_d = comp;
            rd_en_d  = 1'b1;
            ru_pos_d = 1'b0;
            state_d  = RUNDOWN;
          end
        end
        RUNDOWN: begin
          if (zero) do_abort = 1'b1;
          else if (rd_cnt_q == RD_W'(RD_MAX)) begin
            do_exit = 1'b1;
            timeout = 1'b1;
          end else if (comp != rd_pol_q) do_exit = 1'b1;
          else rd_cnt_d = rd_cnt_q + 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // The step counted is the reference actually applied this cycle, i.e. the registered select.
    if (do_step) begin
      ru_pos_d = comp;
      if (ru_pos_q) begin
        if (pos_cnt_q == RU_SAT) ovf_flag_d = 1'b1;
        else pos_cnt_d = pos_cnt_q + 1'b1;
      end else begin
        if (neg_cnt_q == RU_SAT) ovf_flag_d = 1'b1;
        else neg_cnt_d = neg_cnt_q + 1'b1;
      end
    end

    if (do_abort) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      ru_pos_d = 1'b0;
      rd_en_d  = 1'b0;
    end

    if (do_exit) begin
      state_d    = DONE;
      rd_en_d    = 1'b0;
      valid_d    = 1'b1;
      ovf_flag_d = ovf_flag_q | timeout;
      ovf_d      = ovf_flag_q | timeout;
`ifdef MSC_AUTOZERO_EN
      if (az_q) begin
        offset_d = raw;
        result_d = raw;
      end else begin
        result_d = raw - offset_q;
      end
`else
      result_d = raw;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pos_cnt_q  <= '0;
      neg_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      ovf_flag_q <= 1'b0;
      ru_pos_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pol_q   <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef MSC_AUTOZERO_EN
      az_q       <= 1'b0;
      offset_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pos_cnt_q  <= pos_cnt_d;
      neg_cnt_q  <= neg_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      ru_pos_q   <= ru_pos_d;
      rd_en_q    <= rd_en_d;
      rd_pol_q   <= rd_pol_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
`ifdef MSC_AUTOZERO_EN
      az_q       <= az_d;
      offset_q   <= offset_d;
`endif
    end
  end

  assign ru_pos = ru_pos_q;
  assign rd_en  = rd_en_q;
  assign rd_pol = rd_pol_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_msc_result_acc.sv
// Self-checking bench for msc_result_acc: directed sequences plus randomized conversions
// compared against a conversion-level reference model.
module tb_msc_result_acc;
  localparam int RES_W  = 26;
  localparam int RD_MAX = 4095;

  logic clk = 1'b0;
  logic rst, start, runup, zero, comp, az;
  logic ru_pos, rd_en, rd_pol, busy, valid, ovf, err;
  logic [RES_W-1:0] result;

  int checks   = 0;
  int failures = 0;

  // Reference model state: step tallies, reference applied last cycle, autozero bookkeeping.
  int     m_pos, m_neg;
  bit     m_prev, m_az;
  longint m_offset = 0;
  longint m_result = 0;
  bit     m_ovf    = 0;

  always #5 clk = ~clk;

  msc_result_acc dut (
    .clk(clk), .rst(rst), .start(start), .runup(runup), .zero(zero), .comp(comp), .az(az),
    .ru_pos(ru_pos), .rd_en(rd_en), .rd_pol(rd_pol), .busy(busy), .result(result),
    .valid(valid), .ovf(ovf), .err(err)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint sres(input logic [RES_W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic startConv(input bit az_in);
    start = 1'b1; az = az_in; zero = 1'b0; runup = 1'b0;
    tick;
    start = 1'b0; az = 1'b0;
    m_pos = 0; m_neg = 0; m_prev = 1'b0; m_az = az_in;
    checkOutput("busy_arm", busy, 1);
    checkOutput("rd_en_arm", rd_en, 0);
    checkOutput("valid_arm", valid, 0);
    checkOutput("err_arm", err, 0);
  endtask

  task automatic runupPhase(input int n, input bit alt);
    for (int i = 0; i < n; i++) begin
      bit c;
      c = alt ? (i % 2 == 0) : 1'($urandom_range(1, 0));
      comp = c; runup = 1'b1;
      tick;
      if (m_prev) m_pos++;
      else m_neg++;
      m_prev = c;
      checkOutput("ru_pos", ru_pos, c);
    end
  endtask

  task automatic endRunup(input bit pol);
    runup = 1'b0; comp = pol;
    tick;
    m_prev = 1'b0;
    checkOutput("rd_en_on", rd_en, 1);
    checkOutput("rd_pol", rd_pol, pol);
    checkOutput("ru_pos_off", ru_pos, 0);
  endtask

  // Holds comp at pol for rd_len cycles (runup toggled randomly, must be ignored), then releases it.
  task automatic applyStimulus(input bit pol, input int rd_len);
    int  k;
    int  exp_k;
    bit  seen;
    longint raw;
    exp_k = (rd_len < RD_MAX) ? rd_len : RD_MAX;
    seen = 1'b0;
    k = 0;
    while (k < 5000 && !seen) begin
      comp = (k < rd_len) ? pol : ~pol;
      runup = 1'($urandom_range(1, 0));
      tick;
      if (valid) seen = 1'b1;
      else k++;
    end
    runup = 1'b0;
    checkOutput("valid_seen", seen, 1);
    checkOutput("valid_latency", k, exp_k);
    raw = longint'(m_pos - m_neg) * 256 + (pol ? longint'(exp_k) : -longint'(exp_k));
`ifdef MSC_AUTOZERO_EN
    if (m_az) begin
      m_offset = raw;
      m_result = raw;
    end else begin
      m_result = raw - m_offset;
    end
`else
    m_result = raw;
`endif
    m_ovf = (rd_len > RD_MAX);
    checkOutput("result", sres(result), m_result);
    checkOutput("ovf", ovf, m_ovf);
    checkOutput("rd_en_off", rd_en, 0);
    checkOutput("busy_done", busy, 1);
    tick;
    checkOutput("valid_pulse", valid, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("result_hold", sres(result), m_result);
  endtask

  task automatic rundownCycles(input bit pol, input int n);
    for (int i = 0; i < n; i++) begin
      comp = pol; runup = 1'b0;
      tick;
      checkOutput("no_early_valid", valid, 0);
    end
  endtask

  task automatic fullConv(input bit az_in, input int n, input bit alt, input bit pol, input int rd_len);
    startConv(az_in);
    runupPhase(n, alt);
    endRunup(pol);
    applyStimulus(pol, rd_len);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; runup = 1'b0; zero = 1'b0; comp = 1'b0; az = 1'b0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", sres(result), 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    tick;
    rst = 1'b1;

    // Basic balanced conversion: 20/20 steps, 37 rundown cycles.
    fullConv(1'b0, 40, 1'b1, 1'b1, 37);
    checkOutput("t2_result", sres(result), 37);

    // Reset asserted mid-runup clears everything immediately.
    startConv(1'b0);
    runupPhase(15, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ru_pos", ru_pos, 0);
    checkOutput("mid_rst_result", sres(result), 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    checkOutput("mid_rst_rd_pol", rd_pol, 0);
    m_result = 0; m_offset = 0;
    tick;
    rst = 1'b1;
    fullConv(1'b0, 40, 1'b1, 1'b1, 37);

    // Rundown timeout.
    fullConv(1'b0, 40, 1'b1, 1'b1, 5000);
    checkOutput("t3_result", sres(result), 4095);
    checkOutput("t3_ovf", ovf, 1);

    // Zero on runup cycle 10 aborts.
    startConv(1'b0);
    runupPhase(9, 1'b0);
    runup = 1'b1; zero = 1'b1;
    tick;
    zero = 1'b0; runup = 1'b0;
    checkOutput("abort_err", err, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", valid, 0);
    checkOutput("abort_ru_pos", ru_pos, 0);
    tick;
    checkOutput("abort_err_pulse", err, 0);
    checkOutput("abort_result", sres(result), m_result);
    checkOutput("abort_ovf", ovf, m_ovf);

    // Zero in ARM aborts.
    startConv(1'b0);
    zero = 1'b1;
    tick;
    zero = 1'b0;
    checkOutput("arm_abort_err", err, 1);
    checkOutput("arm_abort_busy", busy, 0);

    // Zero in rundown aborts with rd_en dropped.
    startConv(1'b0);
    runupPhase(12, 1'b0);
    endRunup(1'b0);
    rundownCycles(1'b0, 5);
    zero = 1'b1;
    tick;
    zero = 1'b0;
    checkOutput("rd_abort_err", err, 1);
    checkOutput("rd_abort_rd_en", rd_en, 0);
    checkOutput("rd_abort_valid", valid, 0);

    // Start during rundown restarts cleanly.
    startConv(1'b0);
    runupPhase(30, 1'b1);
    endRunup(1'b1);
    rundownCycles(1'b1, 10);
    startConv(1'b0);
    runupPhase(25, 1'b0);
    endRunup(1'b0);
    applyStimulus(1'b0, 60);

    // Start and zero together: start wins.
    startConv(1'b0);
    runupPhase(7, 1'b0);
    start = 1'b1; zero = 1'b1; runup = 1'b0;
    tick;
    start = 1'b0; zero = 1'b0;
    m_pos = 0; m_neg = 0; m_prev = 1'b0; m_az = 1'b0;
    checkOutput("start_zero_err", err, 0);
    checkOutput("start_zero_busy", busy, 1);
    runupPhase(20, 1'b0);
    endRunup(1'b1);
    applyStimulus(1'b1, 15);

    // Autozero pair: raw 37 then raw 100.
    fullConv(1'b1, 40, 1'b1, 1'b1, 37);
    checkOutput("az_first", sres(result), 37);
    fullConv(1'b0, 40, 1'b1, 1'b1, 100);
`ifdef MSC_AUTOZERO_EN
    checkOutput("az_second", sres(result), 63);
`else
    checkOutput("az_second", sres(result), 100);
`endif

    // Randomized conversions.
    for (int r = 0; r < 12; r++) begin
      fullConv(($urandom_range(7, 0) == 0), $urandom_range(200, 1), 1'b0,
               1'($urandom_range(1, 0)), $urandom_range(300, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
